// File: rtl/disk_sector_bridge_pkg.sv
// disk_sector_bridge_pkg: shared command codes, status bit positions and FSM encoding
package disk_sector_bridge_pkg;
    localparam logic [1:0] CMD_IDLE = 2'b00;
    localparam logic [1:0] CMD_READ = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [31:0] CR_IDLE = {CMD_IDLE, 30'd0};
    localparam int SR_ACK = 0;
    localparam int SR_ERR = 1;
    localparam logic [7:0] EMPTY_BYTE = 8'hE5;
    typedef enum logic [2:0] {S_IDLE, S_RD_HOST, S_RD_DRAIN, S_WR_FILL, S_WR_HOST} state_t;
    function automatic logic [31:0] make_cr(input logic [1:0] cmd, input logic drive, input logic [28:0] lba);
        return {cmd, drive, lba};
    endfunction
endpackage

// File: rtl/disk_sector_bridge_sector_ram.sv
// disk_sector_bridge_sector_ram: one-sector byte buffer, synchronous write and registered read
module disk_sector_bridge_sector_ram #(
    parameter int DEPTH = 512,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/disk_sector_bridge.sv
// disk_sector_bridge: buffers one sector between the FDC byte stream and the CtrlModule disk port
module disk_sector_bridge
    import disk_sector_bridge_pkg::*;
#(
    parameter int SECTOR_BYTES = 512,
    parameter int LBA_W = 20,
    parameter int TIMEOUT = 16000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fdc_req_rd,
    input  logic             fdc_req_wr,
    input  logic [LBA_W-1:0] fdc_lba,
    input  logic             fdc_drive,
    output logic             fdc_busy,
    output logic             fdc_error,
    output logic             fdc_data_ready,
    input  logic             fdc_rd_strobe,
    output logic [7:0]       fdc_rd_data,
    input  logic             fdc_wr_strobe,
    input  logic [7:0]       fdc_wr_data,
    output logic [31:0]      disk_cr,
    input  logic [31:0]      disk_sr,
    input  logic [7:0]       disk_data_in,
    input  logic             disk_data_clkin,
    output logic [7:0]       disk_data_out,
    output logic             disk_data_clkout
);
    localparam int PW = $clog2(SECTOR_BYTES);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [PW:0] FULL = (PW + 1)'(SECTOR_BYTES);
    localparam logic [PW:0] LAST = FULL - 1'b1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t state_q, state_d;
    logic [PW:0] ptr_q, ptr_d, ptr_n;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] cr_q, cr_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic drive_q, drive_d, busy_q, busy_d, err_q, err_d, rdy_q, rdy_d;
    logic ack_prev, ack_armed, ack, host_byte, timed_out;
    logic rd_pend_q, rd_pend_d, out_pend_q, out_pend_d;
    logic [7:0] rd_hold_q, rd_hold_d, out_hold_q, out_hold_d;
    logic ram_we;
    logic [7:0] ram_wdata, ram_q;
    logic unused_sr;

    disk_sector_bridge_sector_ram #(.DEPTH(SECTOR_BYTES)) u_ram (
        .clk(clk), .we(ram_we), .addr(ptr_q[PW-1:0]), .wdata(ram_wdata), .rdata(ram_q)
    );

    always_comb begin
        ack = ack_armed && (disk_sr[SR_ACK] != ack_prev);
        host_byte = disk_data_clkin && !ptr_q[PW];
        ptr_n = host_byte ? ptr_q + 1'b1 : ptr_q;
        timed_out = (state_q == S_RD_HOST || state_q == S_WR_HOST) && !ack && !disk_data_clkin && cnt_q == TO_LAST;
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = disk_data_clkin ? '0 : cnt_q + 1'b1;
        cr_d = cr_q;
        lba_d = lba_q;
        drive_d = drive_q;
        busy_d = busy_q;
        err_d = err_q;
        rdy_d = rdy_q;
        rd_pend_d = 1'b0;
        out_pend_d = 1'b0;
        rd_hold_d = rd_pend_q ? ram_q : rd_hold_q;
        out_hold_d = out_pend_q ? ram_q : out_hold_q;
        ram_we = 1'b0;
        ram_wdata = disk_data_in;
        case (state_q)
            S_IDLE: begin
                if (fdc_req_wr && !fdc_req_rd) begin
                    state_d = S_WR_FILL;
                    lba_d = fdc_lba;
                    drive_d = fdc_drive;
                    ptr_d = '0;
                    busy_d = 1'b0;
                    err_d = 1'b0;
                end else if (fdc_rd_strobe && !fdc_req_rd) rd_hold_d = EMPTY_BYTE;
            end
            // the byte arriving with the ack is stored before the length is judged
            S_RD_HOST: begin
                ram_we = host_byte;
                ptr_d = ptr_n;
                if (ack) begin
                    cr_d = CR_IDLE;
                    busy_d = 1'b0;
                    if (!disk_sr[SR_ERR] && ptr_n == FULL) begin
                        state_d = S_RD_DRAIN;
                        ptr_d = '0;
                        rdy_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RD_DRAIN: begin
                if (fdc_rd_strobe) begin
                    rd_pend_d = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        rdy_d = 1'b0;
                        ptr_d = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_WR_FILL: begin
                if (fdc_wr_strobe) begin
                    ram_we = 1'b1;
                    ram_wdata = fdc_wr_data;
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST) begin
                        ptr_d = '0;
                        cr_d = make_cr(CMD_WRITE, drive_q, 29'(lba_q));
                        busy_d = 1'b1;
                        cnt_d = '0;
                        state_d = S_WR_HOST;
                    end
                end
            end
            S_WR_HOST: begin
                out_pend_d = host_byte;
                ptr_d = ptr_n;
                if (ack) begin
                    cr_d = CR_IDLE;
                    busy_d = 1'b0;
                    err_d = disk_sr[SR_ERR] || ptr_n != FULL;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (timed_out) begin
            cr_d = CR_IDLE;
            err_d = 1'b1;
            busy_d = 1'b0;
            state_d = S_IDLE;
        end
        if (fdc_req_rd && (state_q == S_IDLE || state_q == S_RD_DRAIN)) begin
            state_d = S_RD_HOST;
            lba_d = fdc_lba;
            drive_d = fdc_drive;
            ptr_d = '0;
            cnt_d = '0;
            cr_d = make_cr(CMD_READ, fdc_drive, 29'(fdc_lba));
            busy_d = 1'b1;
            err_d = 1'b0;
            rdy_d = 1'b0;
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            cr_q <= CR_IDLE;
            lba_q <= '0;
            drive_q <= 1'b0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
            rdy_q <= 1'b0;
            rd_pend_q <= 1'b0;
            out_pend_q <= 1'b0;
            rd_hold_q <= 8'd0;
            out_hold_q <= 8'd0;
            ack_prev <= 1'b0;
            ack_armed <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            cr_q <= cr_d;
            lba_q <= lba_d;
            drive_q <= drive_d;
            busy_q <= busy_d;
            err_q <= err_d;
            rdy_q <= rdy_d;
            rd_pend_q <= rd_pend_d;
            out_pend_q <= out_pend_d;
            rd_hold_q <= rd_hold_d;
            out_hold_q <= out_hold_d;
            ack_prev <= disk_sr[SR_ACK];
            ack_armed <= 1'b1;
        end
    end

    assign fdc_busy = busy_q;
    assign fdc_error = err_q;
    assign fdc_data_ready = rdy_q;
    assign fdc_rd_data = rd_pend_q ? ram_q : rd_hold_q;
    assign disk_cr = cr_q;
    assign disk_data_out = out_pend_q ? ram_q : out_hold_q;
    assign disk_data_clkout = out_pend_q;
    assign unused_sr = ^disk_sr[31:2];
endmodule

// File: tb/tb_disk_sector_bridge.sv
// tb_disk_sector_bridge: random sector transfers checked every cycle against a transaction-level model
module tb_disk_sector_bridge;
    localparam int SB = 512;
    localparam int LW = 20;
    localparam int TO = 1000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic fdc_req_rd = 1'b0, fdc_req_wr = 1'b0, fdc_drive = 1'b0;
    logic [LW-1:0] fdc_lba = '0;
    logic fdc_busy, fdc_error, fdc_data_ready;
    logic fdc_rd_strobe = 1'b0, fdc_wr_strobe = 1'b0;
    logic [7:0] fdc_rd_data;
    logic [7:0] fdc_wr_data = 8'd0;
    logic [31:0] disk_cr;
    logic [31:0] disk_sr = 32'd0;
    logic [7:0] disk_data_in = 8'd0;
    logic disk_data_clkin = 1'b0;
    logic [7:0] disk_data_out;
    logic disk_data_clkout;
    int checks = 0, errors = 0;
    logic [7:0] sent [1024];
    logic [7:0] wdat [SB];

    always #5 clk = ~clk;

    disk_sector_bridge #(.SECTOR_BYTES(SB), .LBA_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .fdc_req_rd(fdc_req_rd), .fdc_req_wr(fdc_req_wr), .fdc_lba(fdc_lba), .fdc_drive(fdc_drive),
        .fdc_busy(fdc_busy), .fdc_error(fdc_error), .fdc_data_ready(fdc_data_ready),
        .fdc_rd_strobe(fdc_rd_strobe), .fdc_rd_data(fdc_rd_data),
        .fdc_wr_strobe(fdc_wr_strobe), .fdc_wr_data(fdc_wr_data),
        .disk_cr(disk_cr), .disk_sr(disk_sr), .disk_data_in(disk_data_in), .disk_data_clkin(disk_data_clkin),
        .disk_data_out(disk_data_out), .disk_data_clkout(disk_data_clkout)
    );

    // Transaction-level model: phase plus a byte array and a byte count
    typedef enum {P_IDLE, P_READ, P_DRAIN, P_FILL, P_PUSH} phase_t;
    phase_t m_ph = P_IDLE;
    logic [7:0] m_buf [SB];
    int m_n = 0, m_idle = 0;
    logic m_busy = 0, m_err = 0, m_rdy = 0, m_clkout = 0, m_rd_chk = 1, m_out_chk = 1;
    logic m_ackp = 0, m_armed = 0, m_drv = 0, m_ack = 0;
    logic [31:0] m_cr = 0;
    logic [7:0] m_rd = 0, m_out = 0;
    logic [LW-1:0] m_lba = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ph = P_IDLE; m_n = 0; m_idle = 0; m_busy = 0; m_err = 0; m_rdy = 0; m_clkout = 0;
            m_cr = 0; m_rd = 0; m_out = 0; m_rd_chk = 1; m_out_chk = 1; m_armed = 0;
        end else begin
            m_ack = m_armed && (disk_sr[0] != m_ackp);
            m_ackp = disk_sr[0];
            m_armed = 1;
            m_rd_chk = 0; m_out_chk = 0; m_clkout = 0;
            m_idle = disk_data_clkin ? 0 : m_idle + 1;
            if (fdc_req_rd && (m_ph == P_IDLE || m_ph == P_DRAIN)) begin
                m_ph = P_READ; m_n = 0; m_idle = 0; m_busy = 1; m_err = 0; m_rdy = 0;
                m_cr = {2'b01, fdc_drive, 9'd0, fdc_lba};
            end else if (fdc_req_wr && m_ph == P_IDLE) begin
                m_ph = P_FILL; m_n = 0; m_busy = 0; m_err = 0; m_lba = fdc_lba; m_drv = fdc_drive;
            end else begin
                case (m_ph)
                    P_IDLE: if (fdc_rd_strobe) begin m_rd = 8'hE5; m_rd_chk = 1; end
                    P_READ: begin
                        if (disk_data_clkin && m_n < SB) begin m_buf[m_n] = disk_data_in; m_n++; end
                        if (m_ack) begin
                            m_cr = 0; m_busy = 0;
                            if (!disk_sr[1] && m_n == SB) begin m_ph = P_DRAIN; m_n = 0; m_rdy = 1; end
                            else begin m_err = 1; m_ph = P_IDLE; end
                        end else if (m_idle == TO) begin m_cr = 0; m_busy = 0; m_err = 1; m_ph = P_IDLE; end
                    end
                    P_DRAIN: if (fdc_rd_strobe) begin
                        m_rd = m_buf[m_n]; m_rd_chk = 1; m_n++;
                        if (m_n == SB) begin m_rdy = 0; m_ph = P_IDLE; end
                    end
                    P_FILL: if (fdc_wr_strobe) begin
                        m_buf[m_n] = fdc_wr_data; m_n++;
                        if (m_n == SB) begin m_n = 0; m_idle = 0; m_busy = 1; m_ph = P_PUSH; m_cr = {2'b10, m_drv, 9'd0, m_lba}; end
                    end
                    P_PUSH: begin
                        if (disk_data_clkin && m_n < SB) begin m_out = m_buf[m_n]; m_clkout = 1; m_out_chk = 1; m_n++; end
                        if (m_ack) begin m_cr = 0; m_busy = 0; m_err = disk_sr[1] || m_n != SB; m_ph = P_IDLE; end
                        else if (m_idle == TO) begin m_cr = 0; m_busy = 0; m_err = 1; m_ph = P_IDLE; end
                    end
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    task automatic compare_all();
        chk("fdc_busy", 32'(fdc_busy), 32'(m_busy));
        chk("fdc_error", 32'(fdc_error), 32'(m_err));
        chk("fdc_data_ready", 32'(fdc_data_ready), 32'(m_rdy));
        chk("disk_cr", disk_cr, m_cr);
        chk("disk_data_clkout", 32'(disk_data_clkout), 32'(m_clkout));
        if (m_rd_chk) chk("fdc_rd_data", 32'(fdc_rd_data), 32'(m_rd));
        if (m_out_chk) chk("disk_data_out", 32'(disk_data_out), 32'(m_out));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        fdc_req_rd = 0; fdc_req_wr = 0; fdc_rd_strobe = 0; fdc_wr_strobe = 0; disk_data_clkin = 0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic req_read(input logic [LW-1:0] lba, input logic drv);
        fdc_lba = lba; fdc_drive = drv; fdc_req_rd = 1; tick();
    endtask

    task automatic req_write(input logic [LW-1:0] lba, input logic drv);
        fdc_lba = lba; fdc_drive = drv; fdc_req_wr = 1; tick();
    endtask

    task automatic host_ack(input logic err);
        disk_sr[1] = err; disk_sr[0] = ~disk_sr[0]; tick();
    endtask

    task automatic host_send(input int n, input bit pat, input bit ack_last, input logic err);
        for (int i = 0; i < n; i++) begin
            sent[i] = pat ? 8'(i) : 8'($urandom);
            disk_data_in = sent[i]; disk_data_clkin = 1;
            if (ack_last && i == n - 1) begin disk_sr[1] = err; disk_sr[0] = ~disk_sr[0]; end
            tick();
            gap();
        end
    endtask

    task automatic drain(input int n, input bit pin);
        for (int i = 0; i < n; i++) begin
            fdc_rd_strobe = 1; tick();
            if (pin) chk("drain_byte", 32'(fdc_rd_data), 32'(sent[i]));
            gap();
        end
    endtask

    task automatic fill(input bit pat);
        for (int i = 0; i < SB; i++) begin
            wdat[i] = pat ? 8'hA5 ^ 8'(i) : 8'($urandom);
            fdc_wr_data = wdat[i]; fdc_wr_strobe = 1; tick();
            gap();
        end
    endtask

    task automatic pull(input int n, input bit pin, input bit ack_last, input logic err);
        for (int i = 0; i < n; i++) begin
            disk_data_clkin = 1;
            if (ack_last && i == n - 1) begin disk_sr[1] = err; disk_sr[0] = ~disk_sr[0]; end
            tick();
            if (pin) begin
                chk("push_clkout", 32'(disk_data_clkout), 32'd1);
                chk("push_byte", 32'(disk_data_out), 32'(wdat[i]));
            end
            gap();
        end
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_cr", disk_cr, 32'd0);
        chk("rst_busy", 32'(fdc_busy), 32'd0);
        chk("rst_rd_data", 32'(fdc_rd_data), 32'd0);
        chk("rst_clkout", 32'(disk_data_clkout), 32'd0);
        reset_n = 1;
        tick();
        // plain read of a known ramp
        req_read(20'h00123, 1'b1);
        chk("read_cr", disk_cr, 32'h60000123);
        chk("read_busy", 32'(fdc_busy), 32'd1);
        host_send(SB, 1, 0, 0);
        host_ack(0);
        chk("read_ready", 32'(fdc_data_ready), 32'd1);
        chk("read_busy_done", 32'(fdc_busy), 32'd0);
        drain(SB, 1);
        chk("ready_after_last", 32'(fdc_data_ready), 32'd0);
        fdc_rd_strobe = 1; tick();
        chk("idle_strobe", 32'(fdc_rd_data), 32'hE5);
        // write of an 0xA5^i pattern
        req_write(20'd5, 1'b0);
        fill(1);
        chk("write_cr", disk_cr, 32'h80000005);
        chk("write_busy", 32'(fdc_busy), 32'd1);
        pull(SB, 1, 0, 0);
        host_ack(0);
        chk("write_busy_done", 32'(fdc_busy), 32'd0);
        chk("write_error", 32'(fdc_error), 32'd0);
        chk("write_cr_done", disk_cr, 32'd0);
        // host reports an error
        req_read(20'($urandom), 1'($urandom));
        host_send(SB, 0, 0, 0);
        host_ack(1);
        chk("host_err", 32'(fdc_error), 32'd1);
        chk("host_err_ready", 32'(fdc_data_ready), 32'd0);
        // short transfer, then over-long transfer
        req_read(20'($urandom), 1'($urandom));
        host_send(100, 0, 0, 0);
        host_ack(0);
        chk("short_err", 32'(fdc_error), 32'd1);
        req_read(20'($urandom), 1'($urandom));
        host_send(600, 0, 0, 0);
        host_ack(0);
        chk("over_ready", 32'(fdc_data_ready), 32'd1);
        chk("over_err", 32'(fdc_error), 32'd0);
        drain(SB, 1);
        // timeout with no host activity
        req_read(20'h00042, 1'b0);
        repeat (TO - 1) tick();
        chk("to_not_yet", 32'(fdc_error), 32'd0);
        tick();
        chk("to_error", 32'(fdc_error), 32'd1);
        chk("to_cr", disk_cr, 32'd0);
        // reset in the middle of a host write phase
        req_write(20'($urandom), 1'($urandom));
        fill(0);
        pull(300, 0, 0, 0);
        reset_n = 0;
        #1;
        chk("mid_rst_cr", disk_cr, 32'd0);
        chk("mid_rst_busy", 32'(fdc_busy), 32'd0);
        chk("mid_rst_clkout", 32'(disk_data_clkout), 32'd0);
        chk("mid_rst_out", 32'(disk_data_out), 32'd0);
        tick(); tick();
        reset_n = 1;
        tick();
        req_read(20'($urandom), 1'($urandom));
        host_send(SB, 0, 0, 0);
        host_ack(0);
        drain(SB, 1);
        // random mix, including ack on the final byte and partial drains
        for (int t = 0; t < 10; t++) begin
            int n;
            bit al;
            logic e;
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(500, 520) : SB;
            e = 1'($urandom_range(0, 4) == 0);
            al = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) != 0) begin
                req_read(20'($urandom), 1'($urandom));
                host_send(n, 0, al, e);
                if (!al) host_ack(e);
                drain($urandom_range(1, SB), 0);
            end else begin
                req_write(20'($urandom), 1'($urandom));
                fill(0);
                pull(n, 0, al, e);
                if (!al) host_ack(e);
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
